// File: rtl/stage_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches and buffers returned words
// for decode. Redirects flush the buffer and drop responses still in flight for the old stream.
module stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DepthW = (AW+2)'(DEPTH);

    typedef logic [AW:0] ptr_t;

    logic [31:0] pc_q, pc_d;
    ptr_t        outstanding_q, outstanding_d;
    ptr_t        discard_q, discard_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        pq_wr_ptr_q, pq_wr_ptr_d;
    ptr_t        pq_rd_ptr_q, pq_rd_ptr_d;

    logic [31:0] fifo_instr_q [DEPTH];
    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] pq_pc_q      [DEPTH];

    logic [31:0]   target;
    ptr_t          occupancy;
    logic [AW+1:0] credit_used;
    logic          req_fire;
    logic          rsp_acc;
    logic          rsp_keep;
    logic          deq;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign target    = {redirect_pc[31:2], 2'b00};
    assign occupancy = wr_ptr_q - rd_ptr_q;

    assign if_valid  = rst_n && (occupancy != '0) && !redirect_valid;
    assign deq       = if_valid && if_ready;
    assign if_instr  = fifo_instr_q[rd_ptr_q[AW-1:0]];
    assign if_pc     = fifo_pc_q[rd_ptr_q[AW-1:0]];

    // Every outstanding request is guaranteed a FIFO slot when its response lands.
    assign credit_used    = {1'b0, outstanding_q} + {1'b0, occupancy} - (AW+2)'(deq);
    assign imem_req_valid = rst_n && (credit_used < DepthW);
    assign imem_req_addr  = redirect_valid ? target : pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding (e.g. stale ones after reset) are ignored.
    assign rsp_acc  = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep = rsp_acc && (discard_q == '0) && !redirect_valid;

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + ptr_t'(req_fire) - ptr_t'(rsp_acc);
        discard_d     = discard_q;
        wr_ptr_d      = wr_ptr_q + ptr_t'(rsp_keep);
        rd_ptr_d      = rd_ptr_q + ptr_t'(deq);
        pq_wr_ptr_d   = pq_wr_ptr_q + ptr_t'(req_fire);
        pq_rd_ptr_d   = pq_rd_ptr_q + ptr_t'(rsp_acc);

        if (req_fire) begin
            pc_d = imem_req_addr + 32'd4;
        end else if (redirect_valid) begin
            pc_d = target;
        end

        if (redirect_valid) begin
            // A request issued this cycle already belongs to the new stream.
            discard_d = outstanding_q - ptr_t'(rsp_acc);
            rd_ptr_d  = wr_ptr_q;
        end else if (rsp_acc && (discard_q != '0)) begin
            discard_d = discard_q - ptr_t'(1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pq_wr_ptr_q   <= '0;
            pq_rd_ptr_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pq_wr_ptr_q   <= pq_wr_ptr_d;
            pq_rd_ptr_q   <= pq_rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pq_pc_q[pq_wr_ptr_q[AW-1:0]] <= imem_req_addr;
        end
        if (rst_n && rsp_keep) begin
            fifo_instr_q[wr_ptr_q[AW-1:0]] <= imem_rsp_data;
            fifo_pc_q[wr_ptr_q[AW-1:0]]    <= pq_pc_q[pq_rd_ptr_q[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_stage_fetch.sv
// Scoreboard bench for stage_fetch: a latency-configurable memory model returns the address as
// data; expected {instr, pc} pairs are queued by the directed phases and checked by a monitor.
module tb_stage_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic        rst1_n;
    logic        req_valid1;
    logic [31:0] req_addr1;
    logic        if_valid1;
    logic [31:0] if_instr1;
    logic [31:0] if_pc1;
    logic        one1 = 1'b1;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'h0;

    always #5 clk = ~clk;

    stage_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc)
    );

    stage_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk(clk), .rst_n(rst1_n),
        .imem_req_valid(req_valid1), .imem_req_ready(one1),
        .imem_req_addr(req_addr1), .imem_rsp_valid(zero1),
        .imem_rsp_data(zero32), .redirect_valid(zero1),
        .redirect_pc(zero32), .if_valid(if_valid1), .if_ready(zero1),
        .if_instr(if_instr1), .if_pc(if_pc1)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rel = 0;
    mem_t        mem_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];
    int          deq_cyc[$];
    logic [31:0] req_log1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: logs requests (feeding the memory model) and scores every delivered instruction.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
                req_log.push_back(imem_req_addr);
                req_cyc.push_back(cyc);
            end
            if (rst1_n && req_valid1) req_log1.push_back(req_addr1);
            if (if_valid && if_ready) begin
                deq_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got pc %h expected none", if_pc);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("if_pc", if_pc, e[31:0]);
                    chk("if_instr", if_instr, e[63:32]);
                end
            end
        end
    end

    // Advance to just after the next rising edge and present any due memory response.
    task automatic tick();
        mem_t m;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m.addr;
        end
    endtask

    // Returns in the first cycle after reset release (rel).
    task automatic do_reset(input int l);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        tick();
        tick();
        mem_q.delete();
        imem_rsp_valid = 1'b0;
        lat = l;
        exp_q.delete();
        req_log.delete();
        req_cyc.delete();
        deq_cyc.delete();
        rst_n = 1'b1;
        rel   = cyc;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, pc});
    endtask

    task automatic drain(input string name, input int max);
        int n = 0;
        forever begin
            tick();
            if (exp_q.size() == 0) begin
                if_ready = 1'b0;
                break;
            end
            n++;
            if (n >= max) begin
                if_ready = 1'b0;
                break;
            end
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; rst1_n = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;

        // Outputs held low while in reset.
        tick();
        @(negedge clk);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);

        // Phase A: streaming with 1-cycle memory, one instruction per cycle.
        do_reset(1);
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(32'(4 * i));
        drain("a_drain", 20);
        chk("a_first_req_addr", req_log[0], 32'h0);
        chk("a_first_req_cyc", 32'(req_cyc[0]), 32'(rel));
        chk("a_first_deq_cyc", 32'(deq_cyc[0]), 32'(rel + 2));
        chk("a_deq_span", 32'(deq_cyc[3] - deq_cyc[0]), 32'd3);

        // Phase B: decode stalled, credit limit caps requests at DEPTH.
        do_reset(1);
        repeat (10) tick();
        @(negedge clk);
        chk("b_req_count", 32'(req_log.size()), 32'd4);
        chk("b_req_valid_stall", 32'(imem_req_valid), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) push_exp(32'(4 * i));
        if_ready = 1'b1;
        drain("b_drain", 40);
        for (int i = 0; i < 8; i++) chk("b_req_seq", req_log[i], 32'(4 * i));

        // Phase C: redirect with 3 outstanding and one word buffered (3-cycle memory).
        do_reset(3);
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        if_ready       = 1'b1;
        @(negedge clk);
        chk("c_if_valid_redirect", 32'(if_valid), 32'd0);
        chk("c_req_valid_full", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 4; i++) push_exp(32'h100 + 32'(4 * i));
        tick();
        redirect_valid = 1'b0;
        drain("c_drain", 30);
        chk("c_last_old_req", req_log[3], 32'h0000_000C);
        chk("c_first_new_req", req_log[4], 32'h0000_0100);

        // Phase D: redirect coinciding with a request handshake; low bits ignored.
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        if_ready       = 1'b1;
        @(negedge clk);
        chk("d_req_addr", imem_req_addr, 32'h0000_0200);
        chk("d_req_valid", 32'(imem_req_valid), 32'd1);
        for (int i = 0; i < 3; i++) push_exp(32'h200 + 32'(4 * i));
        tick();
        redirect_valid = 1'b0;
        drain("d_drain", 20);
        chk("d_req1", req_log[1], 32'h0000_0204);

        // Phase E: reset mid-flight with 2 buffered and 2 outstanding; memory keeps its stale word.
        do_reset(2);
        repeat (4) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("e_rst_if_valid", 32'(if_valid), 32'd0);
        chk("e_rst_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        rst_n    = 1'b1;
        if_ready = 1'b1;
        req_log.delete();
        for (int i = 0; i < 3; i++) push_exp(32'(4 * i));
        @(negedge clk);
        chk("e_restart_valid", 32'(imem_req_valid), 32'd1);
        chk("e_restart_addr", imem_req_addr, 32'h0);
        drain("e_drain", 20);

        // Phase F: PC wrap from a high reset vector.
        tick();
        rst1_n = 1'b0;
        tick();
        tick();
        rst1_n = 1'b1;
        repeat (8) tick();
        chk("f_req_count", 32'(req_log1.size()), 32'd4);
        chk("f_addr0", req_log1[0], 32'hFFFF_FFF8);
        chk("f_addr1", req_log1[1], 32'hFFFF_FFFC);
        chk("f_addr2", req_log1[2], 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stage_fetch.md
Name: stage_fetch

Overview:
Instruction-fetch stage of the crisp-risc 5-stage RV32I pipeline; sits directly upstream of stage_decode.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel with an unbounded-latency, in-order response channel.
- Buffers returned words in a small FIFO and presents {instruction, pc} to decode with valid/ready.
- Handles redirects from execute (branch/jump) by flushing buffered words and discarding in-flight stale responses.

Parameters:
RESET_PC  32'h0000_0000  PC of first fetch after reset
DEPTH  4  instruction FIFO entries; also max outstanding requests (power of two, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word address of request, bits[1:0] always 0
imem_rsp_valid  input  1  response word valid (in request order, never back-pressured)
imem_rsp_data  input  32  response instruction word
redirect_valid  input  1  execute-stage redirect, one-cycle pulse
redirect_pc  input  32  redirect target; bits[1:0] ignored (treated as 0)
if_valid  output  1  FIFO head valid toward decode
if_ready  input  1  decode accepts head this cycle
if_instr  output  32  instruction at FIFO head
if_pc  output  32  PC of that instruction

Behaviour:
- Reset (rst_n low at a clock edge): pc<=RESET_PC; FIFO emptied; outstanding<=0; discard<=0. While rst_n is low: imem_req_valid=0, if_valid=0. Reset mid-operation drops everything; any response arriving in the cycle reset is sampled is ignored.
- Request address is combinational: imem_req_addr = redirect_valid ? {redirect_pc[31:2],2'b0} : pc.
- Request issues when imem_req_valid && imem_req_ready; issued address+4 is loaded into pc (wraps 32'hFFFF_FFFC -> 0). A redirect with no handshake loads pc<=redirect target.
- Credit rule: imem_req_valid = (outstanding + occupancy - deq) < DEPTH, where deq = if_valid && if_ready. A response therefore always has a free FIFO slot; overflow is impossible.
- outstanding: +1 on request handshake, -1 on any accepted response (kept or discarded); simultaneous +1/-1 nets 0; never exceeds DEPTH.
- Response handling: if discard>0, the word is dropped and discard decrements; otherwise it is written to the FIFO tail with its PC (taken from a per-entry PC queue captured at request time). Written word is visible at if_valid the next cycle (1-cycle rsp->decode latency).
- FIFO: DEPTH entries, circular pointers with wrap bit; enqueue and dequeue in the same cycle are both performed; occupancy unchanged.
- if_valid = (occupancy!=0) && !redirect_valid; if_instr/if_pc are the head entry (don't-care when if_valid=0).
- Redirect cycle:
  - FIFO is flushed (occupancy<=0; any dequeue that cycle is suppressed).
  - discard <= outstanding - (rsp this cycle ? 1 : 0); the response arriving that cycle is dropped.
  - A request handshaking in the redirect cycle belongs to the new stream, fetches the redirect target, sets pc<=target+4, and is not counted in discard.
- Back-to-back redirects: each recomputes discard from current outstanding; the last one wins.
- Sustained throughput: one instruction/cycle with 1-cycle memory latency, imem_req_ready=1, if_ready=1.

Test Plan:
- Reset release, 1-cycle memory returning addr as data, if_ready=1 -> first req addr 0x0 in first cycle after reset; if_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles; if_instr==if_pc.
- if_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, then imem_req_valid=0. After if_ready=1: PCs 0x0..0xC drain in order; fetching resumes at 0x10 with no loss or duplication.
- Redirect to 0x100 with 3 requests outstanding (3-cycle memory latency) -> 3 stale responses dropped; next if_pc=0x100, then 0x104; if_valid=0 during the redirect cycle.
- Redirect pulse with redirect_pc=0x203 in the same cycle as request handshake -> imem_req_addr=0x200 that cycle; next request 0x204; first if_pc=0x200.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Assert rst_n=0 for one cycle while FIFO holds 2 entries and 2 requests are outstanding -> next cycle if_valid=0, imem_req_valid=0; after release, fetch restarts at RESET_PC; late stale responses are not delivered.
